// File: rtl/uart_txfifo.sv
// ----------------------------------------------------------------------------
// uart_txfifo
//   Transmit buffer between the CPU Avalon-MM bus and the uart Avalon write
//   port. The CPU pushes bytes into a FIFO without waiting on each serial
//   transfer. The block drains the FIFO head into the uart, honouring the
//   uart's waitrequest. A low-watermark interrupt lets software refill in
//   bursts.
//
// Ports
//   clk                 in   clock
//   rst                 in   asynchronous, active-low reset
//   avalon_address      in   0: data/status, 1: control
//   avalon_read         in   CPU read strobe (status is always presented)
//   avalon_write        in   CPU write strobe
//   avalon_writedata    in   CPU write data
//   avalon_readdata     out  status word {count @ [8 +: FIFO_LOG+1],
//                            irq_en, status_irq, full, empty}
//   avalon_waitrequest  out  stalls a CPU data write while the FIFO is full
//   status_irq          out  low-watermark interrupt (registered)
//   tx_write            out  to uart avalon_write
//   tx_writedata        out  to uart avalon_writedata (fall-through head)
//   tx_waitrequest      in   from uart avalon_waitrequest
// ----------------------------------------------------------------------------
module uart_txfifo #(
    parameter int BYTESIZE   = 8,
    parameter int ADW        = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_LOG   = $clog2(FIFO_DEPTH),
    parameter int LEVEL_IRQ  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           avalon_address,
    input  logic           avalon_read,
    input  logic           avalon_write,
    input  logic [ADW-1:0] avalon_writedata,
    output logic [ADW-1:0] avalon_readdata,
    output logic           avalon_waitrequest,
    output logic           status_irq,
    output logic           tx_write,
    output logic [ADW-1:0] tx_writedata,
    input  logic           tx_waitrequest
);

    localparam logic [FIFO_LOG:0]   DEPTH_C = (FIFO_LOG+1)'(FIFO_DEPTH);
    localparam logic [FIFO_LOG:0]   LEVEL_C = (FIFO_LOG+1)'(LEVEL_IRQ);
    localparam logic [FIFO_LOG:0]   CNT_ONE = (FIFO_LOG+1)'(1);
    localparam logic [FIFO_LOG-1:0] PTR_ONE = FIFO_LOG'(1);

    logic [BYTESIZE-1:0] mem_r [FIFO_DEPTH];
    logic [FIFO_LOG-1:0] wr_ptr_r;
    logic [FIFO_LOG-1:0] rd_ptr_r;
    logic [FIFO_LOG:0]   count_r;
    logic [FIFO_LOG:0]   count_next_s;
    logic                irq_en_r;
    logic                irq_en_next_s;
    logic                status_irq_r;
    logic                full_s;
    logic                empty_s;
    logic                ctrl_wr_s;
    logic                flush_s;
    logic                push_s;
    logic                pop_s;
    logic                unused_s;

    // Strobe decode; full/empty come from the registered count, so a write
    // to a full FIFO stalls at least one cycle even if a pop happens now.
    assign full_s             = (count_r == DEPTH_C);
    assign empty_s            = (count_r == '0);
    assign ctrl_wr_s          = avalon_write & avalon_address;
    assign flush_s            = ctrl_wr_s & avalon_writedata[1];
    assign push_s             = avalon_write & ~avalon_address & ~full_s;
    assign avalon_waitrequest = avalon_write & ~avalon_address & full_s;
    assign tx_write           = ~empty_s;
    // A flush discards the head, so a pop in the flush cycle is dropped.
    assign pop_s              = tx_write & ~tx_waitrequest & ~flush_s;
    assign tx_writedata       = {{(ADW-BYTESIZE){1'b0}}, mem_r[rd_ptr_r]};
    assign irq_en_next_s      = ctrl_wr_s ? avalon_writedata[0] : irq_en_r;
    assign status_irq         = status_irq_r;

    // Read strobe and upper write-data bits carry no information here.
    assign unused_s = ^{avalon_read, avalon_writedata[ADW-1:BYTESIZE]};

    // Next occupancy; flush dominates, push and pop together cancel out.
    always_comb begin
        count_next_s = count_r;
        if (flush_s) begin
            count_next_s = '0;
        end else if (push_s && !pop_s) begin
            count_next_s = count_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // Status word, combinational so reads never stall.
    always_comb begin
        avalon_readdata                   = '0;
        avalon_readdata[0]                = empty_s;
        avalon_readdata[1]                = full_s;
        avalon_readdata[2]                = status_irq_r;
        avalon_readdata[3]                = irq_en_r;
        avalon_readdata[8 +: FIFO_LOG+1]  = count_r;
    end

    // FIFO storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= avalon_writedata[BYTESIZE-1:0];
        end
    end

    // Pointers, occupancy, interrupt enable and registered interrupt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            irq_en_r     <= 1'b0;
            status_irq_r <= 1'b0;
        end else begin
            if (flush_s) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
            end
            count_r      <= count_next_s;
            irq_en_r     <= irq_en_next_s;
            status_irq_r <= irq_en_next_s & (count_next_s <= LEVEL_C);
        end
    end

endmodule

// File: tb/tb_uart_txfifo.sv
// Bench for uart_txfifo: accepted CPU bytes are queued as expected uart
// writes; a monitor compares every uart transfer against the queue head.
// Status, interrupt and stall behaviour are checked against hand values.
module tb_uart_txfifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        avalon_address = 1'b0;
    logic        avalon_read = 1'b0;
    logic        avalon_write = 1'b0;
    logic [31:0] avalon_writedata = 32'h0;
    logic [31:0] avalon_readdata;
    logic        avalon_waitrequest;
    logic        status_irq;
    logic        tx_write;
    logic [31:0] tx_writedata;
    logic        tx_waitrequest = 1'b1;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q [$];

    uart_txfifo dut (
        .clk                (clk),
        .rst                (rst),
        .avalon_address     (avalon_address),
        .avalon_read        (avalon_read),
        .avalon_write       (avalon_write),
        .avalon_writedata   (avalon_writedata),
        .avalon_readdata    (avalon_readdata),
        .avalon_waitrequest (avalon_waitrequest),
        .status_irq         (status_irq),
        .tx_write           (tx_write),
        .tx_writedata       (tx_writedata),
        .tx_waitrequest     (tx_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completed uart transfer must match the oldest expected byte.
    always @(negedge clk) begin
        if (tx_write === 1'b1 && tx_waitrequest === 1'b0) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL tx_unexpected: got 0x%08h expected no transfer", tx_writedata);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (tx_writedata !== {24'h0, e}) begin
                    n_err++;
                    $display("FAIL tx_data: got 0x%08h expected 0x%08h", tx_writedata, {24'h0, e});
                end
            end
        end
    end

    task automatic cpu_write(input logic adr, input logic [31:0] d);
        int n;
        avalon_address   = adr;
        avalon_writedata = d;
        avalon_write     = 1'b1;
        #1;
        n = 0;
        while (avalon_waitrequest && n < 64) begin
            tick();
            n++;
        end
        if (avalon_waitrequest) begin
            check("write_timeout", 32'(avalon_waitrequest), 32'h0);
        end else if (!adr) begin
            exp_q.push_back(d[7:0]);
        end
        tick();
        avalon_write = 1'b0;
    endtask

    task automatic drain();
        int n;
        tx_waitrequest = 1'b0;
        n = 0;
        while (avalon_readdata[0] !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        tx_waitrequest = 1'b1;
        check("drain_empty", 32'(avalon_readdata[0]), 32'h1);
    endtask

    initial begin
        avalon_read = 1'b1;
        // 1: reset state
        tick(); tick();
        rst = 1'b1;
        tick();
        check("rst_tx_write", 32'(tx_write), 32'h0);
        check("rst_status", avalon_readdata, 32'h0000_0001);
        check("rst_irq", 32'(status_irq), 32'h0);

        // 2: ordering with the uart stalled, then released
        cpu_write(1'b0, 32'hFFFF_FF55);
        cpu_write(1'b0, 32'h0000_00A3);
        cpu_write(1'b0, 32'h1234_560F);
        check("order_count", avalon_readdata, 32'h0000_0300);
        check("order_head_stable", tx_writedata, 32'h0000_0055);
        check("order_tx_write", 32'(tx_write), 32'h1);
        tx_waitrequest = 1'b0;
        tick(); tick(); tick();
        tx_waitrequest = 1'b1;
        check("order_empty", avalon_readdata, 32'h0000_0001);

        // 3: full, stalled 17th write, accepted after one pop
        for (int i = 0; i < 16; i++) cpu_write(1'b0, 32'(i * 7 + 1));
        check("full_status", avalon_readdata, 32'h0000_1002);
        avalon_address   = 1'b0;
        avalon_writedata = 32'h0000_00EE;
        avalon_write     = 1'b1;
        #1;
        check("full_wait0", 32'(avalon_waitrequest), 32'h1);
        tick();
        check("full_wait1", 32'(avalon_waitrequest), 32'h1);
        tx_waitrequest = 1'b0;
        #1;
        check("full_wait_pop_cycle", 32'(avalon_waitrequest), 32'h1);
        tick();
        tx_waitrequest = 1'b1;
        #1;
        check("full_wait_released", 32'(avalon_waitrequest), 32'h0);
        exp_q.push_back(8'hEE);
        tick();
        avalon_write = 1'b0;
        #1;
        check("full_refilled", avalon_readdata, 32'h0000_1002);
        drain();

        // 4: concurrent push+pop with pointer wrap
        for (int i = 0; i < 5; i++) cpu_write(1'b0, 32'(8'(i + 8'hC0)));
        tx_waitrequest = 1'b0;
        for (int i = 0; i < 40; i++) begin
            avalon_address   = 1'b0;
            avalon_writedata = 32'(8'(i * 13 + 7));
            avalon_write     = 1'b1;
            #1;
            check("conc_count", 32'(avalon_readdata[12:8]), 32'h5);
            exp_q.push_back(8'(i * 13 + 7));
            tick();
        end
        avalon_write   = 1'b0;
        tx_waitrequest = 1'b1;
        #1;
        check("conc_final", avalon_readdata, 32'h0000_0500);
        drain();

        // 5: low-watermark interrupt
        cpu_write(1'b1, 32'h0000_0001);
        check("irq_empty", 32'(status_irq), 32'h1);
        for (int i = 0; i < 5; i++) cpu_write(1'b0, 32'(8'(i + 8'h30)));
        check("irq_count5", 32'(status_irq), 32'h0);
        check("irq_status5", avalon_readdata, 32'h0000_0508);
        tx_waitrequest = 1'b0;
        tick();
        tx_waitrequest = 1'b1;
        check("irq_count4", 32'(status_irq), 32'h1);
        check("irq_status4", avalon_readdata, 32'h0000_040C);
        cpu_write(1'b0, 32'h0000_0099);
        check("irq_back5", 32'(status_irq), 32'h0);

        // 6: flush
        for (int i = 0; i < 4; i++) cpu_write(1'b0, 32'(8'(i + 8'h60)));
        check("flush_pre", avalon_readdata, 32'h0000_0908);
        cpu_write(1'b1, 32'h0000_0002);
        exp_q.delete();
        check("flush_tx_write", 32'(tx_write), 32'h0);
        check("flush_status", avalon_readdata, 32'h0000_0001);
        check("flush_irq_off", 32'(status_irq), 32'h0);
        cpu_write(1'b0, 32'h0000_0011);
        cpu_write(1'b0, 32'h0000_0022);
        cpu_write(1'b1, 32'h0000_0003);
        exp_q.delete();
        check("flush_irq_on", 32'(status_irq), 32'h1);
        check("flush_status_en", avalon_readdata, 32'h0000_000D);

        // 1b: reset mid-drain
        for (int i = 0; i < 3; i++) cpu_write(1'b0, 32'(8'(i + 8'hA0)));
        tx_waitrequest = 1'b0;
        tick();
        exp_q.delete();
        rst = 1'b0;
        #1;
        check("rst_mid_tx_write", 32'(tx_write), 32'h0);
        check("rst_mid_status", avalon_readdata, 32'h0000_0001);
        check("rst_mid_irq", 32'(status_irq), 32'h0);
        tick();
        rst = 1'b1;
        tx_waitrequest = 1'b1;
        tick();
        check("rst_after_tx_write", 32'(tx_write), 32'h0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
